// File: rtl/adc_clk_lock_mon_pkg.sv
// Shared types and defaults for the ADC capture-clock lock monitor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package adc_clk_pkg;

   // One-hot channel FSM encoding; bit LOCKED_BIT is the LOCKED flop itself.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_ACQ    = 4'b0010,
      ST_HOLD   = 4'b0100,
      ST_LOCKED = 4'b1000
   } ch_state_e;

   localparam int LOCKED_BIT = 3;

   localparam int WIN_CYC_DEF   = 1024;
   localparam int EDGE_MIN_DEF  = 240;
   localparam int EDGE_MAX_DEF  = 260;
   localparam int LOCK_WINS_DEF = 4;

   // Width of each per-channel loss counter.
   localparam int LOSS_W = 8;

endpackage

// File: rtl/adc_clk_lock_mon_if.sv
// Control/status bundle between the lock monitor and its user.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
// Signals: hb_in (async heartbeats), ch_rearm / loss_clr (pulses in),
//          lock, rst_out_n, all_locked, loss_cnt (status out).
interface adc_clk_lock_mon_if
   import adc_clk_pkg::*;
#(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]        hb_in;
   logic [N_CH-1:0]        ch_rearm;
   logic                   loss_clr;
   logic [N_CH-1:0]        lock;
   logic [N_CH-1:0]        rst_out_n;
   logic                   all_locked;
   logic [N_CH*LOSS_W-1:0] loss_cnt;

   // master: the user side driving heartbeats and control pulses.
   modport master (
      output hb_in, ch_rearm, loss_clr,
      input  lock, rst_out_n, all_locked, loss_cnt
   );

   // slave: the monitor itself.
   modport slave (
      input  hb_in, ch_rearm, loss_clr,
      output lock, rst_out_n, all_locked, loss_cnt
   );
endinterface

// File: rtl/adc_clk_lock_mon_ch.sv
// One channel: heartbeat sync + edge count, lock FSM, hold-off, loss counter.
// Latency: heartbeat edge counted 2 edges after sampling; lock decoded from LOCKED flop.
// Backpressure: none; ch_rearm/loss_clr are single-cycle pulses acted on immediately.
// Ports: clk, rst_n, win_end (shared window strobe), hb (async toggle), rearm,
//        loss_clr, lock, rst_out_n, loss_cnt.
module adc_clk_lock_ch
   import adc_clk_pkg::*;
#(
   parameter int CNT_W     = 10,
   parameter int EDGE_MIN  = EDGE_MIN_DEF,
   parameter int EDGE_MAX  = EDGE_MAX_DEF,
   parameter int LOCK_WINS = LOCK_WINS_DEF,
   parameter int HOLD_CYC  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              win_end,
   input  logic              hb,
   input  logic              rearm,
   input  logic              loss_clr,
   output logic              lock,
   output logic              rst_out_n,
   output logic [LOSS_W-1:0] loss_cnt
);
   localparam int STREAK_W = $clog2(LOCK_WINS + 1);
   localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]    CNT_LO   = CNT_W'(EDGE_MIN);
   localparam logic [CNT_W-1:0]    CNT_HI   = CNT_W'(EDGE_MAX);
   localparam logic [STREAK_W-1:0] STREAK_N = STREAK_W'(LOCK_WINS);
   localparam logic [HOLD_W-1:0]   HOLD_END = HOLD_W'(HOLD_CYC - 1);

   logic                hb_s1, hb_s2, hb_prev;
   logic                hb_edge;
   logic [CNT_W-1:0]    edge_cnt;
   logic                win_good;
   ch_state_e           state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                loss_inc;

   // Heartbeat is a toggle, so both transitions are edges.
   assign hb_edge = hb_s2 ^ hb_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_s1   <= 1'b0;
         hb_s2   <= 1'b0;
         hb_prev <= 1'b0;
      end else begin
         hb_s1   <= hb;
         hb_s2   <= hb_s1;
         hb_prev <= hb_s2;
      end
   end

   // An edge landing in the win_end cycle belongs to the next window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         edge_cnt <= '0;
      else if (win_end)
         edge_cnt <= CNT_W'(hb_edge);
      else if (hb_edge && edge_cnt != CNT_MAX)
         edge_cnt <= edge_cnt + 1'b1;
   end

   assign win_good = (edge_cnt >= CNT_LO) && (edge_cnt <= CNT_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         streak_q <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         hold_q   <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      hold_d   = hold_q;
      loss_inc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d  = ST_ACQ;
            streak_d = '0;
         end
         ST_ACQ: begin
            if (win_end) begin
               if (win_good) begin
                  streak_d = streak_q + 1'b1;
                  if (streak_q + 1'b1 == STREAK_N) begin
                     state_d = ST_HOLD;
                     hold_d  = '0;
                  end
               end else begin
                  streak_d = '0;
               end
            end
         end
         ST_HOLD: begin
            // A bad window outranks hold-off completion in the same cycle.
            if (win_end && !win_good) begin
               state_d  = ST_ACQ;
               streak_d = '0;
               loss_inc = 1'b1;
            end else if (hold_q == HOLD_END) begin
               state_d = ST_LOCKED;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (win_end && !win_good) begin
               state_d  = ST_ACQ;
               streak_d = '0;
               loss_inc = 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            streak_d = '0;
         end
      endcase
      // Rearm discards any window result in the same cycle and is not a loss.
      if (rearm) begin
         state_d  = ST_ACQ;
         streak_d = '0;
         loss_inc = 1'b0;
      end
   end

   // Clear outranks a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         loss_cnt <= '0;
      else if (loss_clr)
         loss_cnt <= '0;
      else if (loss_inc && loss_cnt != '1)
         loss_cnt <= loss_cnt + 1'b1;
   end

   assign lock      = state_q[LOCKED_BIT];
   assign rst_out_n = state_q[LOCKED_BIT];

endmodule

// File: rtl/adc_clk_lock_mon.sv
// Multi-channel ADC capture-clock lock monitor and capture-reset sequencer.
// Latency: lock per channel LOCK_WINS windows + HOLD_CYC after acquisition start; all_locked +1.
// Backpressure: none; status is continuously valid.
// Ports: gclk10m_buf (only clock), sys_rst_n (async active-low), mon (slave bundle).
module adc_clk_lock_mon
   import adc_clk_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int WIN_CYC   = WIN_CYC_DEF,
   parameter int CNT_W     = 10,
   parameter int EDGE_MIN  = EDGE_MIN_DEF,
   parameter int EDGE_MAX  = EDGE_MAX_DEF,
   parameter int LOCK_WINS = LOCK_WINS_DEF,
   parameter int HOLD_CYC  = 256
) (
   input  logic             gclk10m_buf,
   input  logic             sys_rst_n,
   adc_clk_lock_mon_if.slave mon
);
   localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

   logic [WIN_W-1:0]       win_cnt;
   logic                   win_end;
   logic [N_CH-1:0]        lock_vec;
   logic [N_CH-1:0]        rst_vec;
   logic [N_CH*LOSS_W-1:0] loss_vec;
   logic                   all_locked_q;

   // One window counter serves every channel so all windows are aligned.
   assign win_end = (win_cnt == WIN_LAST);

   always_ff @(posedge gclk10m_buf or negedge sys_rst_n) begin
      if (!sys_rst_n)
         win_cnt <= '0;
      else if (win_end)
         win_cnt <= '0;
      else
         win_cnt <= win_cnt + 1'b1;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      adc_clk_lock_ch #(
         .CNT_W     (CNT_W),
         .EDGE_MIN  (EDGE_MIN),
         .EDGE_MAX  (EDGE_MAX),
         .LOCK_WINS (LOCK_WINS),
         .HOLD_CYC  (HOLD_CYC)
      ) u_ch (
         .clk       (gclk10m_buf),
         .rst_n     (sys_rst_n),
         .win_end   (win_end),
         .hb        (mon.hb_in[k]),
         .rearm     (mon.ch_rearm[k]),
         .loss_clr  (mon.loss_clr),
         .lock      (lock_vec[k]),
         .rst_out_n (rst_vec[k]),
         .loss_cnt  (loss_vec[k*LOSS_W +: LOSS_W])
      );
   end

   always_ff @(posedge gclk10m_buf or negedge sys_rst_n) begin
      if (!sys_rst_n)
         all_locked_q <= 1'b0;
      else
         all_locked_q <= &lock_vec;
   end

   assign mon.lock       = lock_vec;
   assign mon.rst_out_n  = rst_vec;
   assign mon.loss_cnt   = loss_vec;
   assign mon.all_locked = all_locked_q;

endmodule

// File: tb/tb_adc_clk_lock_mon.sv
// Bench for adc_clk_lock_mon: default-size instance against a timestamp-based
// lock model, plus a small-window instance that drives loss_cnt to saturation.
// Heartbeat edges are attributed to the cycle two edges after they are sampled.
module tb_adc_clk_lock_mon;
   import adc_clk_pkg::*;

   localparam int N_CH  = 4;
   localparam int WIN   = 1024;
   localparam int HOLD  = 256;
   localparam int LWINS = 4;
   localparam int EMIN  = 240;
   localparam int EMAX  = 260;
   localparam int NONE  = -1;
   localparam int RUN2_LEN = 6000;
   localparam int F_PAIRS  = 302;

   logic clk = 1'b0;
   logic rst_n;
   logic fast_rst_n;
   bit   fast_done = 1'b0;

   always #50 clk = ~clk;

   adc_clk_lock_mon_if #(.N_CH(N_CH)) mon ();
   adc_clk_lock_mon_if #(.N_CH(1))    fmon ();

   adc_clk_lock_mon #(.N_CH(N_CH)) u_dut (
      .gclk10m_buf (clk),
      .sys_rst_n   (rst_n),
      .mon         (mon)
   );

   adc_clk_lock_mon #(
      .N_CH(1), .WIN_CYC(64), .CNT_W(6), .EDGE_MIN(14), .EDGE_MAX(18),
      .LOCK_WINS(1), .HOLD_CYC(4)
   ) u_fast (
      .gclk10m_buf (clk),
      .sys_rst_n   (fast_rst_n),
      .mon         (fmon)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: per channel a good-window streak, the cycle at which
   // LOCKED is due (NONE while acquiring) and the loss count.
   int per[N_CH];
   int ph[N_CH];
   int streak[N_CH];
   int lock_at[N_CH];
   int loss_m[N_CH];
   int q_edge[N_CH][$];
   logic [N_CH-1:0] exp_lock;
   logic            exp_all;

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         streak[i]  = 0;
         lock_at[i] = NONE;
         loss_m[i]  = 0;
         q_edge[i].delete();
      end
      exp_lock = '0;
      exp_all  = 1'b0;
   endtask

   // Apply the rules for the clock edge numbered n.
   task automatic model_step(input int n, input logic [N_CH-1:0] ra);
      int  cnt;
      bit  good;
      exp_all = &exp_lock;
      for (int i = 0; i < N_CH; i++) begin
         if (n % WIN == WIN - 1) begin
            cnt = 0;
            while (q_edge[i].size() > 0 && q_edge[i][0] < n) begin
               void'(q_edge[i].pop_front());
               cnt++;
            end
            good = (cnt >= EMIN) && (cnt <= EMAX);
            if (ra[i]) begin
               // result discarded; rearm handled below
            end else if (!good) begin
               streak[i] = 0;
               if (lock_at[i] != NONE) begin
                  lock_at[i] = NONE;
                  if (loss_m[i] < 255) loss_m[i]++;
               end
            end else if (lock_at[i] == NONE) begin
               streak[i]++;
               if (streak[i] == LWINS) lock_at[i] = n + 1 + HOLD;
            end
         end
         if (ra[i]) begin
            streak[i]  = 0;
            lock_at[i] = NONE;
         end
         exp_lock[i] = (lock_at[i] != NONE) && (n + 1 >= lock_at[i]);
      end
   endtask

   task automatic check_outputs(input string where);
      logic [N_CH*LOSS_W-1:0] el;
      el = '0;
      for (int i = 0; i < N_CH; i++) el[i*LOSS_W +: LOSS_W] = LOSS_W'(loss_m[i]);
      chk({where, " lock"},       64'(mon.lock),       64'(exp_lock));
      chk({where, " rst_out_n"},  64'(mon.rst_out_n),  64'(exp_lock));
      chk({where, " all_locked"}, 64'(mon.all_locked), 64'(exp_all));
      chk({where, " loss_cnt"},   64'(mon.loss_cnt),   64'(el));
   endtask

   // Main instance: run 1 = clean lock, ch1 loss, ch0 rearm, reset in HOLD;
   // run 2 = relock after reset with ch2 too fast.
   initial begin
      int n;
      int stop_at, rearm_at, rst_at;
      logic [N_CH-1:0] ra;
      rst_n        = 1'b0;
      mon.hb_in    = '0;
      mon.ch_rearm = '0;
      mon.loss_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");

      stop_at  = 4352 + $urandom_range(0, 200);
      rearm_at = WIN * $urandom_range(6, 7) - 1;
      rst_at   = rearm_at + 1 + 4 * WIN + $urandom_range(8, 240);

      for (int run = 1; run <= 2; run++) begin
         for (int i = 0; i < N_CH; i++) begin
            per[i] = (run == 2 && i == 2) ? 3 : 4;
            ph[i]  = $urandom_range(0, per[i] - 1);
         end
         rst_n = 1'b1;
         n = 0;
         forever begin
            check_outputs($sformatf("r%0d c%0d", run, n));
            if (run == 1 && n == rst_at) begin
               rst_n = 1'b0;
               #1;
               chk("async_rst lock",       64'(mon.lock),       64'd0);
               chk("async_rst rst_out_n",  64'(mon.rst_out_n),  64'd0);
               chk("async_rst all_locked", 64'(mon.all_locked), 64'd0);
               chk("async_rst loss_cnt",   64'(mon.loss_cnt),   64'd0);
               mon.hb_in    = '0;
               mon.ch_rearm = '0;
               model_reset();
               repeat (3) @(negedge clk);
               check_outputs("in_reset");
               break;
            end
            if (run == 2 && n == RUN2_LEN) break;
            if (run == 1 && n == stop_at) per[1] = 0;
            ra = '0;
            if (run == 1 && n == rearm_at) ra[0] = 1'b1;
            mon.ch_rearm = ra;
            for (int i = 0; i < N_CH; i++) begin
               if (per[i] != 0 && (n + ph[i]) % per[i] == 0) begin
                  mon.hb_in[i] = ~mon.hb_in[i];
                  q_edge[i].push_back(n + 2);
               end
            end
            @(posedge clk);
            model_step(n, ra);
            @(negedge clk);
            n++;
         end
      end

      wait (fast_done);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Small instance: alternate good/bad 64-cycle windows so every second
   // window is a loss from LOCKED; clear coincides with the 301st loss.
   initial begin
      int k, exp_loss;
      fast_rst_n    = 1'b0;
      fmon.hb_in    = '0;
      fmon.ch_rearm = '0;
      fmon.loss_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("fast reset loss_cnt", 64'(fmon.loss_cnt), 64'd0);
      chk("fast reset lock",     64'(fmon.lock),     64'd0);
      fast_rst_n = 1'b1;
      for (int m = 0; m < F_PAIRS * 128 + 1; m++) begin
         if (m > 0 && m % 128 == 0) begin
            k = m / 128 - 1;
            if (k < 300)       exp_loss = (k + 1 < 255) ? k + 1 : 255;
            else if (k == 300) exp_loss = 0;
            else               exp_loss = 1;
            chk($sformatf("fast loss_cnt c%0d", m), 64'(fmon.loss_cnt), 64'(exp_loss));
            chk($sformatf("fast lock_lost c%0d", m), 64'(fmon.lock), 64'd0);
         end
         if (m % 128 == 72) begin
            chk($sformatf("fast lock c%0d", m),       64'(fmon.lock),       64'd1);
            chk($sformatf("fast rst_out_n c%0d", m),  64'(fmon.rst_out_n),  64'd1);
            chk($sformatf("fast all_locked c%0d", m), 64'(fmon.all_locked), 64'd1);
         end
         fmon.loss_clr = (m == 300 * 128 + 127);
         if ((m % 128) < 64 && (m % 4) == 0) fmon.hb_in[0] = ~fmon.hb_in[0];
         @(negedge clk);
      end
      fmon.loss_clr = 1'b0;
      fast_done = 1'b1;
   end

endmodule
